// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the two-master bus arbiter:
//   arb_state_t   - arbiter FSM state encoding (IDLE / GNT0 / GNT1)
//   M0_IDX/M1_IDX - master index values held in the last-grant pointer
//   TIMEOUT_RDATA - read data returned to a master whose access timed out
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// bus_timeout_counter
// Counts cycles spent waiting on the slave while a grant is held and flags
// when CYCLES full wait cycles have elapsed.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   enable   - count this cycle (a grant is active)
//   clear    - restart from zero (arbiter is idle, so every grant starts fresh)
//   expired  - CYCLES wait cycles have elapsed without completion
// ---------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // Holds at the terminal value; the arbiter leaves the grant on expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(CYCLES));

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master (m0 = CPU, m1 = DMA) round-robin arbiter in front of a single
// slave decode. One transfer at a time, never preempted; every completion or
// abort passes through IDLE for one cycle before the next grant.
//
// Optional feature (macro BUS_TIMEOUT_EN): a grant that waits TIMEOUT_CYCLES
// cycles without s_ready is completed with TIMEOUT_RDATA and sets the sticky
// timeout_err flag (cleared by err_clr). Without the macro there is no
// counter, timeout_err is tied 0 and err_clr is ignored.
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   m0_*/m1_* valid,addr,
//     wdata,wstrb           - master requests (wstrb == 0 means read)
//   m0_*/m1_* ready,rdata   - per-master completion pulse and read data
//   s_valid,s_addr,s_wdata,
//     s_wstrb               - request routed from the granted master
//   s_ready,s_rdata         - slave completion and read data
//   grant                   - one-hot owner (bit0 m0, bit1 m1), 00 when idle
//   timeout_err, err_clr    - sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clr
);

    import bus_arb_pkg::*;

    arb_state_t  state;
    logic        last_grant;
    logic        own0;
    logic        own1;
    logic        cur_valid;
    logic        expired;
    logic        timeout_hit;
    logic        done;
    logic [31:0] rdata_sel;

    assign own0      = (state == GNT0);
    assign own1      = (state == GNT1);
    assign cur_valid = (own0 && m0_valid) || (own1 && m1_valid);

    // A completion needs the owner still requesting; s_ready outside a grant
    // never reaches this term, so it is ignored in IDLE.
    assign timeout_hit = cur_valid && expired;
    assign done        = cur_valid && (s_ready || expired);
    assign rdata_sel   = timeout_hit ? TIMEOUT_RDATA : s_rdata;

    assign m0_ready = own0 && done;
    assign m1_ready = own1 && done;
    assign m0_rdata = m0_ready ? rdata_sel : 32'h0;
    assign m1_rdata = m1_ready ? rdata_sel : 32'h0;

    // Slave request follows the owner; withdrawn in the timeout cycle.
    always_comb begin
        s_valid = 1'b0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        s_wstrb = 4'h0;
        if (own0) begin
            s_valid = m0_valid && !expired;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (own1) begin
            s_valid = m1_valid && !expired;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= M1_IDX;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master not served last wins.
                    if (m0_valid && (!m1_valid || last_grant == M1_IDX)) begin
                        state <= GNT0;
                        grant <= 2'b01;
                    end else if (m1_valid) begin
                        state <= GNT1;
                        grant <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_valid) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (done) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_grant <= M0_IDX;
                    end
                end
                GNT1: begin
                    if (!m1_valid) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (done) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        last_grant <= M1_IDX;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    bus_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (own0 || own1),
        .clear   (state == IDLE),
        .expired (expired)
    );

    // A timeout in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expired            = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = err_clr | (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: reset, single read, round-robin tie,
// write routing, abort, reset mid-transfer, and timeout behaviour for the
// configured build (BUS_TIMEOUT_EN on or off). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready  = 1'b0; s_rdata = 32'h0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        m0_addr = 32'h0000_0010;
        sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid got=%b exp=0", s_valid); end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL rst_s_addr got=%h exp=0", s_addr); end
        checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {m0_ready, m1_ready}); end
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
        step();
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        m0_valid = 1'b1; m0_addr = 32'h0002_0000; m0_wstrb = 4'h0;
        sample();
        checks++; if (grant !== 2'b00 || s_valid !== 1'b0) begin errors++; $display("FAIL rd_arb_latency got grant=%b s_valid=%b exp=00/0", grant, s_valid); end
        step(); sample();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant got=%b exp=01", grant); end
        checks++; if (s_valid !== 1'b1 || s_addr !== 32'h0002_0000 || s_wstrb !== 4'h0) begin errors++; $display("FAIL rd_route got v=%b a=%h s=%h exp 1/00020000/0", s_valid, s_addr, s_wstrb); end
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got=%b exp=0", m0_ready); end
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        sample();
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_done got rdy=%b data=%h exp 1/12345678", m0_ready, m0_rdata); end
        checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rd_other got rdy=%b data=%h exp 0/0", m1_ready, m1_rdata); end
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        sample();
        checks++; if (grant !== 2'b00 || m0_ready !== 1'b0) begin errors++; $display("FAIL rd_back_idle got grant=%b rdy=%b exp 00/0", grant, m0_ready); end
        step();
    endtask

    task automatic test_tie_back_to_back();
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++; if (grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL tie_idle_%0d got grant=%b rdy=%b%b exp 00/00", k, grant, m1_ready, m0_ready); end
            step(); sample();
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL tie_grant_%0d got=%b exp=%b", k, grant, exp_g); end
            checks++; if (s_addr !== exp_a || {m1_ready, m0_ready} !== exp_g) begin errors++; $display("FAIL tie_route_%0d got a=%h rdy=%b%b exp a=%h rdy=%b", k, s_addr, m1_ready, m0_ready, exp_a, exp_g); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_write_routing();
        m0_valid = 1'b0; m0_addr = 32'h1111_1111; m0_wdata = 32'h2222_2222; m0_wstrb = 4'hF;
        m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'hCAFE_0001; m1_wstrb = 4'b0001;
        sample();
        step(); sample();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant got=%b exp=10", grant); end
        checks++; if (s_valid !== 1'b1 || s_addr !== 32'h8000_0000 || s_wdata !== 32'hCAFE_0001 || s_wstrb !== 4'b0001) begin errors++; $display("FAIL wr_route got v=%b a=%h d=%h s=%b", s_valid, s_addr, s_wdata, s_wstrb); end
        step();
        s_ready = 1'b1;
        sample();
        checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready got m1=%b m0=%b exp 1/0", m1_ready, m0_ready); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_m0_rdata got=%h exp=0", m0_rdata); end
        step();
        idle_inputs();
    endtask

    task automatic test_abort();
        m0_valid = 1'b1; m0_addr = 32'h0000_0040;
        sample();
        step(); sample();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ab_grant got=%b exp=01", grant); end
        step();
        m0_valid = 1'b0;
        sample();
        checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL ab_drop got v=%b rdy=%b exp 0/0", s_valid, m0_ready); end
        step(); sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ab_idle got=%b exp=00", grant); end
        // last served before the abort was m1, so m0 must win this tie
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        step(); sample();
        checks++; if (grant !== 2'b01 || m0_ready !== 1'b1) begin errors++; $display("FAIL ab_tie got grant=%b rdy=%b exp 01/1", grant, m0_ready); end
        step();
        m0_valid = 1'b0;
        sample();
        step(); sample();
        checks++; if (grant !== 2'b10 || m1_ready !== 1'b1 || m1_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL ab_m1_next got grant=%b rdy=%b data=%h", grant, m1_ready, m1_rdata); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_transfer();
        m1_valid = 1'b1; m1_addr = 32'h0000_3000; m1_wdata = 32'h7777_7777; m1_wstrb = 4'hF;
        sample();
        step(); sample();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rm_grant got=%b exp=10", grant); end
        #1;
        reset_n = 1'b0; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF; m0_valid = 1'b1;
        #1;
        checks++; if (grant !== 2'b00 || s_valid !== 1'b0) begin errors++; $display("FAIL rm_grant_sv got grant=%b v=%b exp 00/0", grant, s_valid); end
        checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin errors++; $display("FAIL rm_bus got a=%h d=%h s=%h exp 0", s_addr, s_wdata, s_wstrb); end
        checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m1_rdata !== 32'h0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL rm_ready got %b%b %h %h exp 0", m1_ready, m0_ready, m1_rdata, m0_rdata); end
        step();
        reset_n = 1'b1; s_ready = 1'b0;
        sample();
        step(); sample();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_first_tie got=%b exp=01", grant); end
        idle_inputs();
        step(); step();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        m0_valid = 1'b1; m0_addr = 32'h0000_4000;
        sample();
        step();
        for (int i = 0; i < TMO; i++) begin
            sample();
            checks++; if (m0_ready !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL to_wait_%0d got rdy=%b grant=%b exp 0/01", i, m0_ready, grant); end
            step();
        end
        sample();
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_resp got rdy=%b data=%h exp 1/deadbeef", m0_ready, m0_rdata); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL to_s_valid got=%b exp=0", s_valid); end
        step();
        m0_valid = 1'b0;
        sample();
        checks++; if (timeout_err !== 1'b1 || grant !== 2'b00) begin errors++; $display("FAIL to_flag got err=%b grant=%b exp 1/00", timeout_err, grant); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        sample();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
        step();
        idle_inputs();
    endtask
`else
    task automatic test_no_timeout();
        m0_valid = 1'b1; m0_addr = 32'h0000_4000; err_clr = 1'b1;
        step();
        for (int i = 0; i < 3 * TMO; i++) step();
        sample();
        checks++; if (grant !== 2'b01 || m0_ready !== 1'b0) begin errors++; $display("FAIL nt_wait got grant=%b rdy=%b exp 01/0", grant, m0_ready); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL nt_flag got=%b exp=0", timeout_err); end
        s_ready = 1'b1; s_rdata = 32'h0000_BEEF;
        #1;
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL nt_done got rdy=%b data=%h exp 1/0000beef", m0_ready, m0_rdata); end
        step();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_tie_back_to_back();
        test_write_routing();
        test_abort();
        test_reset_mid_transfer();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
